// File: rtl/uart_pkg.sv
// Shared constants for the word-level UART transmit scheduler: FSM encoding and
// default CPU-visible addresses.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_WAIT = 2'd3
  } tx_state_e;

  localparam logic [31:0] DEF_TX_ADDR   = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_STAT_ADDR = 32'hFFFF_FFFC;
  localparam logic [1:0]  LAST_BYTE_IDX = 2'd3;

endpackage

// File: rtl/uart_word_fifo.sv
// Word FIFO with wrap-around pointers one bit wider than the address, so full and
// empty are told apart without a separate counter.
module uart_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_d    = wr_q + (AW+1)'(do_push);
  assign rd_d    = rd_q + (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign level_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_tx_sched.sv
// CPU-facing word scheduler: buffers 32-bit writes and feeds them LSB-first, one byte
// at a time, to a byte UART. Status register read-back is enabled by UART_TX_SCHED_STATUS_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] TX_ADDR    = DEF_TX_ADDR,
  parameter logic [31:0] STAT_ADDR  = DEF_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        full,
  output logic        busy,
  output logic        overflow,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(FIFO_DEPTH);

  tx_state_e   state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;
  logic        done_prev_q, ovf_q, ovf_d;
  logic        push, pop, fifo_empty, done_rise, word_avail, tx_hit;
  logic [31:0] fifo_dout;
  logic [AW:0] level;

  assign tx_hit    = we && (address == TX_ADDR);
  assign push      = tx_hit && !full;
  assign done_rise = tx_done && !done_prev_q;
  // A write landing this cycle already counts, so a fresh word goes straight to LOAD.
  assign word_avail = !fifo_empty || push;

  uart_word_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (dataIn),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (word_avail) state_d = S_LOAD;
      S_LOAD: state_d = S_SEND;
      S_SEND: if (!tx_active) state_d = S_WAIT;
      S_WAIT: if (done_rise) begin
        if (idx_q != LAST_BYTE_IDX) state_d = S_SEND;
        else if (word_avail)        state_d = S_LOAD;
        else                        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_dv   = (state_q == S_SEND) && !tx_active;
    pop     = (state_q == S_LOAD);
    shift_d = shift_q;
    idx_d   = idx_q;
    if (pop) begin
      shift_d = fifo_dout;
      idx_d   = 2'd0;
    end else if ((state_q == S_WAIT) && done_rise && (idx_q != LAST_BYTE_IDX)) begin
      shift_d = {8'h00, shift_q[31:8]};
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q     <= '0;
      idx_q       <= '0;
      done_prev_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      done_prev_q <= tx_done;
      ovf_q       <= ovf_d;
    end
  end

  assign tx_byte  = shift_q[7:0];
  assign busy     = (level != '0) || (state_q != S_IDLE);
  assign overflow = ovf_q;

`ifdef UART_TX_SCHED_STATUS_EN
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    ovf_d = ovf_q;
    if (tx_hit && full)                     ovf_d = 1'b1;
    else if (we && (address == STAT_ADDR))  ovf_d = 1'b0;
    rdata_d = (address == STAT_ADDR) ?
              {16'h0000, ovf_q, busy, full, 5'b00000, 8'(level)} : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`else
  always_comb begin
    ovf_d = ovf_q | (tx_hit && full);
  end

  assign rdata = 32'h0;
`endif

endmodule
